// File: rtl/speed_window_ctrl.sv
// speed_window_ctrl: measurement-window sequencer for the motor speed path.
// Synchronises the raw encoder pulse, counts its rising edges over back-to-back
// gate windows of WINDOW_CYCLES clocks, latches each saturated count onto out
// and presents it with a valid/ready handshake.
//
// Optional feature: define SPEED_DEBOUNCE_EN to insert a glitch filter that
// requires DEB_CYCLES consecutive equal samples before the level changes.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   enable     1 = run windows continuously, 0 = abort and idle
//   pulse      raw encoder pulse, asynchronous to clk
//   out_ready  consumer accepts out when out_valid & out_ready
//   out        edge count of the last completed window (saturating)
//   out_valid  out holds an unconsumed result
//   overflow   count currently on out saturated
//   overrun    sticky: a result was replaced before it was accepted
//   busy       high while a window is being gated
module speed_window_ctrl #(
  parameter int unsigned WINDOW_CYCLES = 40_000_000,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned WIN_W         = 26,
  parameter int unsigned DEB_CYCLES    = 4000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             pulse,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out,
  output logic             out_valid,
  output logic             overflow,
  output logic             overrun,
  output logic             busy
);

  typedef enum logic [0:0] {StIdle, StGate} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

  // Pulse synchroniser and edge detect
  logic [1:0] sync_q;
  logic       lvl;
  logic       lvl_prev_q;
  logic       strobe;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q     <= 2'b00;
      lvl_prev_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], pulse};
      lvl_prev_q <= lvl;
    end
  end

`ifdef SPEED_DEBOUNCE_EN
  localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);

  logic             flt_q;
  logic [DEB_W-1:0] deb_q;

  // Level flips only after DEB_CYCLES consecutive samples that disagree with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flt_q <= 1'b0;
      deb_q <= '0;
    end else if (sync_q[1] == flt_q) begin
      deb_q <= '0;
    end else if (deb_q == DEB_W'(DEB_CYCLES - 1)) begin
      flt_q <= sync_q[1];
      deb_q <= '0;
    end else begin
      deb_q <= deb_q + 1'b1;
    end
  end

  assign lvl = flt_q;
`else
  logic unused_deb;
  assign unused_deb = ^DEB_CYCLES;
  assign lvl        = sync_q[1];
`endif

  assign strobe = lvl & ~lvl_prev_q;

  // Window FSM and result register
  state_e           state_q, state_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             overrun_q, overrun_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      win_q     <= '0;
      cnt_q     <= '0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      overrun_q <= overrun_d;
    end
  end

  // Count including any strobe this cycle, held at CNT_MAX once reached
  assign cnt_inc = (strobe && (cnt_q != CNT_MAX)) ? cnt_q + 1'b1 : cnt_q;

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    valid_d   = valid_q;
    ovf_d     = ovf_q;
    overrun_d = overrun_q;

    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        win_d = '0;
        cnt_d = '0;
        if (enable) begin
          state_d = StGate;
        end
      end
      StGate: begin
        if (win_q == WIN_LAST) begin
          // A result landing in the same cycle as acceptance simply wins.
          out_d   = cnt_inc;
          ovf_d   = (cnt_inc == CNT_MAX);
          valid_d = 1'b1;
          if (valid_q && !out_ready) begin
            overrun_d = 1'b1;
          end
          win_d = '0;
          cnt_d = '0;
        end else begin
          win_d = win_q + 1'b1;
          cnt_d = cnt_inc;
        end
        if (!enable) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign overflow  = ovf_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q == StGate);

endmodule

// File: tb/tb_speed_window_ctrl.sv
module tb_speed_window_ctrl;

`ifdef SPEED_DEBOUNCE_EN
  localparam int GLITCH_EXP = 25;
`else
  localparam int GLITCH_EXP = 50;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       pulse;
  logic       out_ready;
  logic [7:0] dout;
  logic       out_valid;
  logic       overflow;
  logic       overrun;
  logic       busy;

  int total = 0;
  int bad   = 0;

  // Pulse generator controls: period 0 holds the pin low
  int period = 0;
  bit glitch = 1'b0;

  speed_window_ctrl #(
    .WINDOW_CYCLES(1000),
    .CNT_W        (8),
    .WIN_W        (10),
    .DEB_CYCLES   (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .pulse    (pulse),
    .out_ready(out_ready),
    .out      (dout),
    .out_valid(out_valid),
    .overflow (overflow),
    .overrun  (overrun),
    .busy     (busy)
  );

  initial forever #5 clk = ~clk;

  // Square wave of the given period; glitch adds a 2-cycle high blip in the low half
  initial begin
    int ph;
    ph    = 0;
    pulse = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (period == 0) begin
        pulse = 1'b0;
        ph    = 0;
      end else begin
        if (ph >= period) ph = 0;
        pulse = (ph < period / 2) ||
                (glitch && ((ph == period / 2 + 10) || (ph == period / 2 + 11)));
        ph++;
      end
    end
  end

  task automatic wait_result(input string nm, input int limit, output logic [7:0] v,
                             output logic ov, output int n);
    bit got;
    got = 1'b0;
    n   = 0;
    v   = '0;
    ov  = 1'b0;
    while (n < limit) begin
      @(negedge clk);
      n++;
      if (out_valid) begin
        v   = dout;
        ov  = overflow;
        got = 1'b1;
        break;
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s_timeout: got no out_valid want out_valid within %0d cycles", nm, limit);
    end
  endtask

  task automatic test_reset;
    reset     = 1'b0;
    enable    = 1'b1;
    out_ready = 1'b0;
    period    = 2;
    repeat (5) @(negedge clk);
    total++;
    if (dout !== 8'd0) begin bad++; $display("FAIL reset_out: got %0d want 0", dout); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    total++;
    if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    enable    = 1'b0;
    period    = 0;
    out_ready = 1'b1;
    reset     = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_count;
    logic [7:0] v;
    logic       ov;
    int         n;
    period = 40;
    repeat (60) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL count_busy: got %b want 1", busy); end
    wait_result("count_first", 1100, v, ov, n);
    total++;
    if (v !== 8'd25) begin bad++; $display("FAIL count_first_out: got %0d want 25", v); end
    for (int i = 0; i < 3; i++) begin
      wait_result("count_win", 1100, v, ov, n);
      total++;
      if (v !== 8'd25) begin bad++; $display("FAIL count_out[%0d]: got %0d want 25", i, v); end
      total++;
      if (ov !== 1'b0) begin bad++; $display("FAIL count_ovf[%0d]: got %b want 0", i, ov); end
      total++;
      if (n !== 1000) begin bad++; $display("FAIL count_spacing[%0d]: got %0d want 1000", i, n); end
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL count_valid_pulse: got %b want 0", out_valid);
    end
  endtask

  task automatic test_saturate;
    logic [7:0] v;
    logic       ov;
    int         n;
    period = 2;
    wait_result("sat_skip", 1100, v, ov, n);
    wait_result("sat", 1100, v, ov, n);
    total++;
    if (v !== 8'd255) begin bad++; $display("FAIL sat_out: got %0d want 255", v); end
    total++;
    if (ov !== 1'b1) begin bad++; $display("FAIL sat_ovf: got %b want 1", ov); end
    period = 40;
    wait_result("unsat_skip", 1100, v, ov, n);
    wait_result("unsat", 1100, v, ov, n);
    total++;
    if (v !== 8'd25) begin bad++; $display("FAIL unsat_out: got %0d want 25", v); end
    total++;
    if (ov !== 1'b0) begin bad++; $display("FAIL unsat_ovf: got %b want 0", ov); end
  endtask

  task automatic test_overrun;
    logic [7:0] v;
    logic       ov;
    int         n;
    @(negedge clk);
    out_ready = 1'b0;
    wait_result("ovr_first", 1100, v, ov, n);
    total++;
    if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_before: got %b want 0", overrun); end
    n = 0;
    while (n < 1100 && !overrun) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n !== 1000) begin bad++; $display("FAIL ovr_timing: got %0d want 1000", n); end
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid: got %b want 1", out_valid); end
    total++;
    if (dout !== 8'd25) begin bad++; $display("FAIL ovr_out: got %0d want 25", dout); end
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL ovr_accept: got %b want 0", out_valid); end
    total++;
    if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky1: got %b want 1", overrun); end
    wait_result("ovr_next", 1100, v, ov, n);
    total++;
    if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky2: got %b want 1", overrun); end
  endtask

  task automatic test_abort;
    logic [7:0] v;
    logic       ov;
    int         n;
    bit         seen;
    wait_result("abort_pre", 1100, v, ov, n);
    repeat (500) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
    total++;
    if (dout !== 8'd25) begin bad++; $display("FAIL abort_out_kept: got %0d want 25", dout); end
    seen = 1'b0;
    repeat (1200) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL abort_idle_valid: got %b want 0", seen); end
    enable = 1'b1;
    wait_result("abort_restart", 1100, v, ov, n);
    total++;
    if (n !== 1001) begin bad++; $display("FAIL abort_full_window: got %0d want 1001", n); end
    total++;
    if (v !== 8'd25) begin bad++; $display("FAIL abort_restart_out: got %0d want 25", v); end
  endtask

  task automatic test_glitch;
    logic [7:0] v;
    logic       ov;
    int         n;
    glitch = 1'b1;
    wait_result("glitch_skip", 1100, v, ov, n);
    wait_result("glitch", 1100, v, ov, n);
    total++;
    if (v !== 8'(GLITCH_EXP)) begin
      bad++;
      $display("FAIL glitch_out: got %0d want %0d", v, GLITCH_EXP);
    end
    glitch = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count();
    test_saturate();
    test_overrun();
    test_abort();
    test_glitch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
